// File: rtl/speed_ctrl_n_if.sv
// Button inputs and level/pause/tick outputs of the speed controller.
interface speed_ctrl_n_if #(
    parameter int LEVEL_W = 2
);
    logic               pause_btn;
    logic               up_btn;
    logic               down_btn;
    logic [LEVEL_W-1:0] level;
    logic               paused;
    logic               tick;

    modport master (
        output pause_btn, up_btn, down_btn,
        input  level, paused, tick
    );

    modport slave (
        input  pause_btn, up_btn, down_btn,
        output level, paused, tick
    );
endinterface

// File: rtl/speed_ctrl_n.sv
// Speed/pause controller: debounced buttons, saturating level,
// pause state and level-dependent step tick.
module speed_ctrl_n #(
    parameter int NUM_LEVELS      = 4,
    parameter int RESET_LEVEL     = 1,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int BASE_PERIOD     = 4,
    parameter int LEVEL_W         = $clog2(NUM_LEVELS)
) (
    input  logic          clk,
    input  logic          rst_n,
    speed_ctrl_n_if.slave bus
);
    localparam int MAX_PERIOD = BASE_PERIOD << (NUM_LEVELS - 1);
    localparam int CNT_W      = $clog2(MAX_PERIOD);
    localparam int DB_W       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [LEVEL_W-1:0] TOP_LVL = LEVEL_W'(NUM_LEVELS - 1);
    localparam logic [LEVEL_W-1:0] RST_LVL = LEVEL_W'(RESET_LEVEL);

    typedef enum logic {RUN, HOLD} state_e;

    state_e             state_q, state_d;
    logic [2:0]         raw, sync1_q, sync2_q;
    logic [2:0]         filt_q, filt_d, prev_q, press;
    logic [DB_W-1:0]    cnt_q [3];
    logic [DB_W-1:0]    cnt_d [3];
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [CNT_W-1:0]   tcnt_q, tcnt_d, per_m1;
    logic               oor, up_ev, dn_ev, changed, tick_w;

    // bit 2 pause, bit 1 up, bit 0 down
    assign raw   = {bus.pause_btn, bus.up_btn, bus.down_btn};
    assign press = filt_q & ~prev_q;

    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != filt_q[i]) begin
                if (cnt_q[i] + DB_W'(1) == DB_W'(DEBOUNCE_CYCLES))
                    filt_d[i] = sync2_q[i];
                else
                    cnt_d[i] = cnt_q[i] + DB_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        oor     = int'(level_q) >= NUM_LEVELS;
        up_ev   = press[1] & ~press[0] & ~press[2] & ~oor;
        dn_ev   = press[0] & ~press[1] & ~press[2] & ~oor;
        if (press[2])
            state_d = (state_q == RUN) ? HOLD : RUN;
        unique case (1'b1)
            oor:     level_d = RST_LVL;
            up_ev:   if (level_q != TOP_LVL) level_d = level_q + LEVEL_W'(1);
            dn_ev:   if (level_q != '0) level_d = level_q - LEVEL_W'(1);
            default: ;
        endcase
        changed = (state_d != state_q) | (level_d != level_q);
    end

    always_comb begin
        per_m1 = '0;
        for (int i = 0; i < NUM_LEVELS; i++)
            if (int'(level_q) == i)
                per_m1 = CNT_W'((BASE_PERIOD << (NUM_LEVELS - 1 - i)) - 1);
    end

    always_comb begin
        tick_w = 1'b0;
        tcnt_d = tcnt_q + CNT_W'(1);
        if (state_q == HOLD || changed) begin
            tcnt_d = '0;
        end else if (tcnt_q == per_m1) begin
            tick_w = 1'b1;
            tcnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            filt_q  <= '0;
            prev_q  <= '0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
            state_q <= RUN;
            level_q <= RST_LVL;
            tcnt_q  <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            prev_q  <= filt_q;
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
            state_q <= state_d;
            level_q <= level_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign bus.level  = level_q;
    assign bus.paused = (state_q == HOLD);
    assign bus.tick   = tick_w;
endmodule
